// File: rtl/cordic_vector_if.sv
// Start/done handshake bundle for cordic_vector: operands in, angle/magnitude out.
interface cordic_vector_if;
   logic               start;
   logic signed [31:0] x_in;
   logic signed [31:0] y_in;
   logic               ready;
   logic               done;
   logic signed [31:0] angle;
   logic        [31:0] magnitude;

   modport master (output start, x_in, y_in, input ready, done, angle, magnitude);
   modport slave  (input start, x_in, y_in, output ready, done, angle, magnitude);
endinterface

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (x,y) -> angle in degrees and magnitude; done ITERATIONS+1 cycles after start,
// one job at a time (start ignored while busy). CORDIC_VECTOR_GAIN_COMP_EN adds a 1/K scale cycle.
module cordic_vector #(
   parameter int FPSHIFT    = 8,
   parameter int ITERATIONS = 16
) (
   input logic            clk,
   input logic            resetn,
   cordic_vector_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ITER, SCALE, FINISH} state_t;

   localparam logic [3:0]         LAST   = 4'(ITERATIONS - 1);
   localparam int                 RSH    = (FPSHIFT >= 16) ? 0 : 15 - FPSHIFT;
   localparam logic [31:0]        RND    = (FPSHIFT >= 16) ? 32'd0 : 32'(1 << RSH);
   localparam int                 DSH    = 16 - FPSHIFT;
   localparam logic signed [31:0] DEG180 = 32'(180 << FPSHIFT);

   state_t             state, state_nx;
   logic [3:0]         cnt;
   logic signed [33:0] x, y;
   logic signed [31:0] z;
   logic               zero;
   logic               load, step, fin;
   logic signed [31:0] a_i;

   // atan(2^-i) in degrees, 16 fractional bits
   function automatic logic [31:0] atan_t(input logic [3:0] i);
      case (i)
         4'd0:    return 32'd2949120;
         4'd1:    return 32'd1740967;
         4'd2:    return 32'd919879;
         4'd3:    return 32'd466945;
         4'd4:    return 32'd234379;
         4'd5:    return 32'd117304;
         4'd6:    return 32'd58666;
         4'd7:    return 32'd29335;
         4'd8:    return 32'd14668;
         4'd9:    return 32'd7334;
         4'd10:   return 32'd3667;
         4'd11:   return 32'd1833;
         4'd12:   return 32'd917;
         4'd13:   return 32'd458;
         4'd14:   return 32'd229;
         default: return 32'd115;
      endcase
   endfunction

   assign a_i = $signed((atan_t(cnt) + RND) >> DSH);

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = ITER;
         ITER:    if (cnt == LAST) begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            state_nx = SCALE;
`else
            state_nx = FINISH;
`endif
         end
         SCALE:   state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state == IDLE);
      load      = (state == IDLE) && bus.start;
      step      = (state == ITER);
      fin       = (state == FINISH);
   end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   localparam logic signed [50:0] INV_K = 51'sd39797;
   logic signed [50:0] prod, scaled;
   assign prod   = 51'(x) * INV_K;
   assign scaled = (prod + 51'sd32768) >>> 16;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         x             <= '0;
         y             <= '0;
         z             <= '0;
         cnt           <= '0;
         zero          <= 1'b0;
         bus.done      <= 1'b0;
         bus.angle     <= '0;
         bus.magnitude <= '0;
      end else begin
         bus.done <= fin;
         if (load) begin
            cnt  <= '0;
            zero <= (bus.x_in == 32'sd0) && (bus.y_in == 32'sd0);
            if (!bus.x_in[31]) begin
               x <= 34'(bus.x_in);
               y <= 34'(bus.y_in);
               z <= '0;
            end else begin
               // fold left half-plane into the right so the iterations converge
               x <= -34'(bus.x_in);
               y <= -34'(bus.y_in);
               z <= bus.y_in[31] ? -DEG180 : DEG180;
            end
         end else if (step) begin
            cnt <= cnt + 4'd1;
            if (!y[33]) begin
               x <= x + (y >>> cnt);
               y <= y - (x >>> cnt);
               z <= z + a_i;
            end else begin
               x <= x - (y >>> cnt);
               y <= y + (x >>> cnt);
               z <= z - a_i;
            end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
         end else if (state == SCALE) begin
            x <= scaled[33:0];
`endif
         end else if (fin) begin
            // (0,0) never rotates, so z would otherwise accumulate the whole table
            bus.angle     <= zero ? 32'sd0 : z;
            bus.magnitude <= (x[33:31] != 3'b000) ? 32'h7FFF_FFFF : x[31:0];
         end
      end
   end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector (FPSHIFT=8, ITERATIONS=16): latency, quadrants, handshake, reset.
module tb_cordic_vector;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   cordic_vector_if bus ();

   cordic_vector #(.FPSHIFT(8), .ITERATIONS(16)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   localparam int LAT    = 18;
   localparam int MAG100 = 36204;
   localparam int MAGTOL = 4;
   localparam int MAGAX  = 25600;
   localparam int AXTOL  = 4;
`else
   localparam int LAT    = 17;
   localparam int MAG100 = 59620;
   localparam int MAGTOL = 6;
   localparam int MAGAX  = 42157;
   localparam int AXTOL  = 8;
`endif

   function automatic int adiff(input int a, input int b);
      int d;
      d = a - b;
      return (d < 0) ? -d : d;
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (lat = edges after E0, -1 on timeout).
   task automatic run_conv(input int xv, input int yv, input int poke_n, input int px, input int py,
                           output int lat, output logic rdy0);
      bus.start = 1'b1;
      bus.x_in  = xv;
      bus.y_in  = yv;
      @(negedge clk);
      bus.start = 1'b0;
      rdy0 = bus.ready;
      lat  = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == poke_n) begin
            bus.start = 1'b1;
            bus.x_in  = px;
            bus.y_in  = py;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", bus.ready); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", bus.done); end
      checks++; if (bus.angle !== 32'sd0) begin failures++; $display("FAIL reset_angle: got %0d want 0", bus.angle); end
      checks++; if (bus.magnitude !== 32'd0) begin failures++; $display("FAIL reset_mag: got %0d want 0", bus.magnitude); end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; logic rdy0;
      run_conv(25600, 25600, 0, 0, 0, lat, rdy0);
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL busy_ready: got %0b want 0", rdy0); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
      checks++; if (adiff(int'(bus.angle), 11520) > 3) begin failures++; $display("FAIL basic_angle: got %0d want 11520+/-3", bus.angle); end
      checks++; if (adiff(int'(bus.magnitude), MAG100) > MAGTOL) begin failures++; $display("FAIL basic_mag: got %0d want %0d+/-%0d", bus.magnitude, MAG100, MAGTOL); end
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL done_ready: got %0b want 1", bus.ready); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse: got %0b want 0", bus.done); end
      checks++; if (adiff(int'(bus.angle), 11520) > 3) begin failures++; $display("FAIL angle_hold: got %0d want 11520+/-3", bus.angle); end
   endtask

   task automatic test_quadrants();
      int lat; logic rdy0;
      run_conv(-25600, 0, 0, 0, 0, lat, rdy0);
      checks++; if (adiff(int'(bus.angle), 46080) > 3) begin failures++; $display("FAIL neg_x_angle: got %0d want 46080+/-3", bus.angle); end
      checks++; if (adiff(int'(bus.magnitude), MAGAX) > AXTOL) begin failures++; $display("FAIL neg_x_mag: got %0d want %0d+/-%0d", bus.magnitude, MAGAX, AXTOL); end
      @(negedge clk);
      run_conv(0, -25600, 0, 0, 0, lat, rdy0);
      checks++; if (adiff(int'(bus.angle), -23040) > 3) begin failures++; $display("FAIL neg_y_angle: got %0d want -23040+/-3", bus.angle); end
      checks++; if (adiff(int'(bus.magnitude), MAGAX) > AXTOL) begin failures++; $display("FAIL neg_y_mag: got %0d want %0d+/-%0d", bus.magnitude, MAGAX, AXTOL); end
      @(negedge clk);
      run_conv(-25600, -25600, 0, 0, 0, lat, rdy0);
      checks++; if (adiff(int'(bus.angle), -34560) > 3) begin failures++; $display("FAIL q3_angle: got %0d want -34560+/-3", bus.angle); end
      checks++; if (adiff(int'(bus.magnitude), MAG100) > MAGTOL) begin failures++; $display("FAIL q3_mag: got %0d want %0d+/-%0d", bus.magnitude, MAG100, MAGTOL); end
      @(negedge clk);
   endtask

   task automatic test_zero();
      int lat; logic rdy0;
      run_conv(0, 0, 0, 0, 0, lat, rdy0);
      checks++; if (lat != LAT) begin failures++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
      checks++; if (bus.angle !== 32'sd0) begin failures++; $display("FAIL zero_angle: got %0d want 0", bus.angle); end
      checks++; if (bus.magnitude !== 32'd0) begin failures++; $display("FAIL zero_mag: got %0d want 0", bus.magnitude); end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat; logic rdy0;
      run_conv(25600, 25600, 5, 0, -25600, lat, rdy0);
      checks++; if (lat != LAT) begin failures++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
      checks++; if (adiff(int'(bus.angle), 11520) > 3) begin failures++; $display("FAIL ignore_angle: got %0d want 11520+/-3", bus.angle); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat; logic rdy0;
      run_conv(25600, 25600, 0, 0, 0, lat, rdy0);
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
      run_conv(0, -25600, 0, 0, 0, lat, rdy0);
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
      checks++; if (adiff(int'(bus.angle), -23040) > 3) begin failures++; $display("FAIL b2b_angle: got %0d want -23040+/-3", bus.angle); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat; int seen; logic rdy0;
      bus.start = 1'b1;
      bus.x_in  = 25600;
      bus.y_in  = 25600;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %0b want 1", bus.ready); end
      checks++; if (bus.angle !== 32'sd0) begin failures++; $display("FAIL midrst_angle: got %0d want 0", bus.angle); end
      checks++; if (bus.magnitude !== 32'd0) begin failures++; $display("FAIL midrst_mag: got %0d want 0", bus.magnitude); end
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_done: got %0d want 0", seen); end
      run_conv(-25600, 0, 0, 0, 0, lat, rdy0);
      checks++; if (lat != LAT) begin failures++; $display("FAIL midrst_after_latency: got %0d want %0d", lat, LAT); end
      checks++; if (adiff(int'(bus.angle), 46080) > 3) begin failures++; $display("FAIL midrst_after_angle: got %0d want 46080+/-3", bus.angle); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_quadrants();
      test_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
